// File: rtl/decoder_sel_if.sv
// Select-generator bus: raw operator inputs in, decoder select out.
interface decoder_sel_if;
  logic       btn_up;
  logic       btn_dn;
  logic       auto_en;
  logic       hold;
  logic [1:0] sel;
  logic       sel_chg;
  logic       mode;

  modport master (
    input  btn_up, btn_dn, auto_en, hold,
    output sel, sel_chg, mode
  );

  modport slave (
    output btn_up, btn_dn, auto_en, hold,
    input  sel, sel_chg, mode
  );
endinterface

// File: rtl/decoder_sel_gen.sv
// Select generator for the 2-to-4 decoder: debounced manual
// stepping or prescaled round-robin scan, with a change pulse.
module decoder_sel_gen #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int SCAN_DIV     = 8
) (
  input logic          clk,
  input logic          rst_n,
  decoder_sel_if.master bus
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [0:0] MANUAL = 1'b0;
  localparam logic [0:0] AUTO   = 1'b1;

  // bit 0 = up, bit 1 = dn, bit 2 = auto_en
  logic [2:0] s1_q, s1_d;
  logic [2:0] s2_q, s2_d;

  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0]         dly_q, dly_d;
  logic [1:0]         press;

  logic [0:0]    mode_q, mode_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [1:0]    sel_q, sel_d;
  logic          chg_q, chg_d;

  always_comb begin
    s1_d = {bus.auto_en, bus.btn_dn, bus.btn_up};
    s2_d = s1_q;
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYC)) begin
          lvl_d[i] = ~lvl_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    dly_d = lvl_q;
    press = lvl_q & ~dly_q;
  end

  always_comb begin
    mode_d = s2_q[2];
    psc_d  = psc_q;
    sel_d  = sel_q;
    chg_d  = 1'b0;
    if (mode_q == MANUAL) begin
      psc_d = '0;
      case (press)
        2'b01: begin
          sel_d = sel_q + 2'd1;
          chg_d = 1'b1;
        end
        2'b10: begin
          sel_d = sel_q - 2'd1;
          chg_d = 1'b1;
        end
        default: ;
      endcase
    end else if (mode_d != mode_q) begin
      psc_d = '0;
    end else if (!bus.hold) begin
      // terminal count advances the scan and wraps the prescaler
      if (psc_q == PW'(SCAN_DIV - 1)) begin
        psc_d = '0;
        sel_d = sel_q + 2'd1;
        chg_d = 1'b1;
      end else begin
        psc_d = psc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cnt_q  <= '0;
      lvl_q  <= '0;
      dly_q  <= '0;
      mode_q <= MANUAL;
      psc_q  <= '0;
      sel_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      dly_q  <= dly_d;
      mode_q <= mode_d;
      psc_q  <= psc_d;
      sel_q  <= sel_d;
      chg_q  <= chg_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.sel_chg = chg_q;
  assign bus.mode    = mode_q[0];

endmodule

// File: tb/tb_decoder_sel_gen.sv
// Randomized and directed bench for decoder_sel_gen against
// a cycle-level behavioural model of the select generator.
module tb_decoder_sel_gen;

  localparam int DEB = 4;
  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  decoder_sel_if bif ();

  decoder_sel_gen #(
    .DEBOUNCE_CYC(DEB),
    .SCAN_DIV    (DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  // model state
  bit       qu[$];
  bit       qd[$];
  bit       qa[$];
  bit       m_lvl_up, m_lvl_dn;
  int       m_run_up, m_run_dn;
  bit       pend_up, pend_dn;
  int       m_ticks;
  bit [1:0] m_sel;
  bit       m_chg;
  bit       m_mode;

  task automatic m_reset();
    qu = '{1'b0, 1'b0};
    qd = '{1'b0, 1'b0};
    qa = '{1'b0, 1'b0};
    m_lvl_up = 0; m_lvl_dn = 0;
    m_run_up = 0; m_run_dn = 0;
    pend_up = 0; pend_dn = 0;
    m_ticks = 0;
    m_sel = 0; m_chg = 0; m_mode = 0;
  endtask

  // level flips on the (DEB+1)th consecutive mismatching edge
  task automatic deb(input bit s, inout bit lvl,
                     inout int run, output bit ev);
    ev = 0;
    if (s != lvl) begin
      run++;
      if (run > DEB) begin
        lvl = ~lvl;
        run = 0;
        ev  = lvl;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic m_edge();
    bit       su, sd, new_mode, old_mode, eu, ed;
    bit [1:0] prev;
    old_mode = m_mode;
    new_mode = qa.pop_front(); qa.push_back(bif.auto_en);
    su = qu.pop_front(); qu.push_back(bif.btn_up);
    sd = qd.pop_front(); qd.push_back(bif.btn_dn);
    prev = m_sel;
    if (!old_mode) begin
      m_ticks = 0;
      m_sel = 2'((int'(m_sel) + int'(pend_up) - int'(pend_dn) + 4) % 4);
    end else if (!new_mode) begin
      m_ticks = 0;
    end else if (!bif.hold) begin
      m_ticks++;
      if (m_ticks == DIV) begin
        m_ticks = 0;
        m_sel = 2'((int'(m_sel) + 1) % 4);
      end
    end
    m_chg = (m_sel != prev);
    deb(su, m_lvl_up, m_run_up, eu);
    deb(sd, m_lvl_dn, m_run_dn, ed);
    pend_up = eu;
    pend_dn = ed;
    m_mode = new_mode;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if (bif.sel !== m_sel || bif.sel_chg !== m_chg ||
          bif.mode !== m_mode) begin
        fails++;
        $display("FAIL model t=%0t sel %0d want %0d chg %0b want %0b mode %0b want %0b",
                 $time, bif.sel, m_sel, bif.sel_chg, m_chg, bif.mode, m_mode);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit up, input bit dn);
    bif.btn_up = up;
    bif.btn_dn = dn;
    cyc(10);
    bif.btn_up = 1'b0;
    bif.btn_dn = 1'b0;
    cyc(10);
  endtask

  task automatic wait_sel(input int val, input int max);
    int n;
    n = 0;
    while (int'(bif.sel) != val && n < max) begin
      cyc(1);
      n++;
    end
    chk("wait_sel_timeout", int'(n < max), 1);
  endtask

  int       s0;
  bit       saw;

  initial begin
    bif.btn_up = 0; bif.btn_dn = 0;
    bif.auto_en = 0; bif.hold = 0;

    // 1: reset with toggling buttons
    for (int i = 0; i < 6; i++) begin
      bif.btn_up = i[0];
      bif.btn_dn = ~i[0];
      cyc(1);
    end
    chk("rst_sel", int'(bif.sel), 0);
    chk("rst_chg", int'(bif.sel_chg), 0);
    chk("rst_mode", int'(bif.mode), 0);
    bif.btn_up = 0; bif.btn_dn = 0;
    rst_n = 1'b1;
    cyc(12);

    // 2: long clean press -> single step at t+7
    bif.btn_up = 1'b1;
    cyc(1);
    cyc(6);
    chk("press_early", int'(bif.sel), 0);
    cyc(1);
    chk("press_sel", int'(bif.sel), 1);
    chk("press_chg", int'(bif.sel_chg), 1);
    cyc(1);
    chk("press_chg_off", int'(bif.sel_chg), 0);
    cyc(11);
    bif.btn_up = 1'b0;
    cyc(10);
    chk("press_once", int'(bif.sel), 1);

    // 3: bouncing input never qualifies
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      bif.btn_up = ~i[0];
      repeat (2) begin
        cyc(1);
        if (bif.sel_chg) saw = 1;
      end
    end
    bif.btn_up = 1'b0;
    repeat (10) begin
      cyc(1);
      if (bif.sel_chg) saw = 1;
    end
    chk("bounce_sel", int'(bif.sel), 1);
    chk("bounce_chg", int'(saw), 0);

    // 4: wrap up, step down, simultaneous press
    repeat (3) press(1, 0);
    chk("up_to_0", int'(bif.sel), 0);
    for (int i = 1; i <= 4; i++) begin
      press(1, 0);
      chk("up_step", int'(bif.sel), i % 4);
    end
    press(0, 1);
    chk("dn_wrap", int'(bif.sel), 3);
    press(1, 1);
    chk("up_dn_same", int'(bif.sel), 3);

    // 5: AUTO scan, hold, ignored buttons
    bif.auto_en = 1'b1;
    cyc(2);
    chk("auto_mode_early", int'(bif.mode), 0);
    cyc(1);
    chk("auto_mode", int'(bif.mode), 1);
    for (int k = 0; k < 4; k++) begin
      s0 = int'(bif.sel);
      cyc(7);
      chk("auto_hold_val", int'(bif.sel), s0);
      cyc(1);
      chk("auto_step", int'(bif.sel), (s0 + 1) % 4);
      chk("auto_chg", int'(bif.sel_chg), 1);
    end
    s0 = int'(bif.sel);
    cyc(2);
    bif.hold = 1'b1;
    cyc(5);
    bif.hold = 1'b0;
    cyc(5);
    chk("hold_delay", int'(bif.sel), s0);
    cyc(1);
    chk("hold_step", int'(bif.sel), (s0 + 1) % 4);
    press(1, 0);
    press(0, 1);

    // 6: reset mid-AUTO at sel=10
    wait_sel(2, 64);
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", int'(bif.sel), 0);
    chk("midrst_mode", int'(bif.mode), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("rel_mode_early", int'(bif.mode), 0);
    cyc(1);
    chk("rel_mode", int'(bif.mode), 1);
    cyc(7);
    chk("rel_no_step", int'(bif.sel), 0);
    cyc(1);
    chk("rel_step", int'(bif.sel), 1);

    // randomized phase
    bif.auto_en = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(7) == 0) bif.btn_up = ~bif.btn_up;
      if ($urandom_range(7) == 0) bif.btn_dn = ~bif.btn_dn;
      if ($urandom_range(299) == 0) bif.auto_en = ~bif.auto_en;
      bif.hold = ($urandom_range(3) == 0);
      if ($urandom_range(1499) == 0) begin
        rst_n = 1'b0;
        cyc($urandom_range(3, 1));
        rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
